play_ctrl: RTL and testbench

Playback sequencer that feeds the slow-speed interpolation datapath. It fetches 16-bit audio samples from SRAM and paces them against the DAC sample tick. Fast speeds skip samples. Slow speeds hold each sample for S ticks and flag the held ticks for the interpolator. It sits between the top-level key/FSM logic and the interpolator/DAC path, and owns the SRAM read address.

---
 rtl/play_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_play_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/play_ctrl.sv
// Playback sequencer: fetches samples from SRAM and paces them against the DAC tick,
// skipping samples at fast speed and holding them (with shift pulses) at slow speed.
// Optional tick-overrun detection is enabled by defining PLAY_CTRL_UNDERRUN_EN.
module play_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_tick,
  input  logic              i_fast,
  input  logic [3:0]        i_speed,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_rd,
  input  logic [DATA_W-1:0] i_sram_data,
  output logic              o_valid,
  output logic              o_shift,
  output logic [DATA_W-1:0] o_data,
  output logic              o_itp_mode,
  output logic [3:0]        o_itp_speed,
  output logic              o_itp_pause,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun,
  output logic [1:0]        o_dbg_state
);

  // Handshakes: o_sram_rd is a one-cycle strobe with o_sram_addr held stable; i_sram_data
  // is taken exactly RD_LAT cycles later with no back-pressure. o_valid, o_shift and
  // o_done are one-cycle pulses to the interpolator, which has no ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_READY = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t              r_state;
  state_t              w_state_n;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_n;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_n;
  logic                r_last;
  logic                w_last_n;
  logic                r_pend;
  logic                w_pend_n;
  logic                r_fetch;
  logic [2:0]          r_lat;
  logic                r_staged;
  logic [DATA_W-1:0]   r_stage;
  logic                r_rd;
  logic                r_valid;
  logic                r_shift;
  logic                r_done;
  logic [DATA_W-1:0]   r_data;
  logic                r_mode;
  logic [3:0]          r_speed;
  logic                r_pause;

  logic                w_fetch_go;
  logic                w_kill;
  logic                w_svc;
  logic                w_valid_n;
  logic                w_shift_n;
  logic                w_done_n;
  logic [3:0]          w_s;
  logic [3:0]          w_step;
  logic [ADDR_W:0]     w_sum;
  logic                w_over;
  logic                w_cap;
  logic                w_tick;

  always_comb begin
    w_s = i_speed;
    if (i_speed == 4'd0) begin
      w_s = 4'd1;
    end else if (i_speed > 4'd8) begin
      w_s = 4'd8;
    end
  end

  // One extra bit so a wrap past the top of SRAM still reads as "beyond the end".
  assign w_step = i_fast ? w_s : 4'd1;
  assign w_sum  = {1'b0, r_addr} + {{(ADDR_W-3){1'b0}}, w_step};
  assign w_over = (w_sum > {1'b0, i_end_addr});
  assign w_cap  = r_fetch && (r_lat == LAT);
  assign w_tick = i_tick && !i_pause;

  always_comb begin
    w_state_n  = r_state;
    w_addr_n   = r_addr;
    w_cnt_n    = r_cnt;
    w_last_n   = r_last;
    w_pend_n   = r_pend;
    w_fetch_go = 1'b0;
    w_kill     = 1'b0;
    w_svc      = 1'b0;
    w_valid_n  = 1'b0;
    w_shift_n  = 1'b0;
    w_done_n   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_n  = S_FETCH;
          w_addr_n   = '0;
          w_last_n   = 1'b0;
          w_pend_n   = 1'b0;
          w_fetch_go = 1'b1;
        end
      end

      S_FETCH: begin
        if (w_tick) begin
          w_pend_n = 1'b1;
        end
        if (w_cap || r_staged) begin
          w_state_n = S_READY;
        end
      end

      S_READY: begin
        if ((i_tick || r_pend) && !i_pause) begin
          w_pend_n = 1'b0;
          if (r_last) begin
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
            w_addr_n  = '0;
            w_last_n  = 1'b0;
            w_cnt_n   = 4'd0;
          end else begin
            w_valid_n = 1'b1;
            w_svc     = 1'b1;
            w_cnt_n   = w_s - 4'd1;
            if (w_over) begin
              w_last_n = 1'b1;
            end else begin
              w_addr_n = w_sum[ADDR_W-1:0];
            end
            // Held groups prefetch the next sample while the shifts play out.
            if (!i_fast && (w_s > 4'd1)) begin
              w_state_n  = S_HOLD;
              w_fetch_go = !w_over;
            end else if (!w_over) begin
              w_state_n  = S_FETCH;
              w_fetch_go = 1'b1;
            end
          end
        end
      end

      S_HOLD: begin
        if (w_tick) begin
          w_shift_n = 1'b1;
          w_cnt_n   = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_n = (r_last || r_staged || w_cap) ? S_READY : S_FETCH;
          end
        end
      end

      default: w_state_n = S_IDLE;
    endcase

    if (i_stop) begin
      w_state_n  = S_IDLE;
      w_addr_n   = '0;
      w_cnt_n    = 4'd0;
      w_last_n   = 1'b0;
      w_pend_n   = 1'b0;
      w_fetch_go = 1'b0;
      w_kill     = 1'b1;
      w_svc      = 1'b0;
      w_valid_n  = 1'b0;
      w_shift_n  = 1'b0;
      w_done_n   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= 4'd0;
      r_last  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_last_n;
      r_pend  <= w_pend_n;
    end
  end

  // Fetch engine runs independently of the FSM so HOLD can overlap it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd     <= 1'b0;
      r_fetch  <= 1'b0;
      r_lat    <= 3'd0;
      r_staged <= 1'b0;
      r_stage  <= '0;
    end else if (w_kill) begin
      r_rd     <= 1'b0;
      r_fetch  <= 1'b0;
      r_lat    <= 3'd0;
      r_staged <= 1'b0;
    end else if (w_fetch_go) begin
      r_rd     <= 1'b1;
      r_fetch  <= 1'b1;
      r_lat    <= 3'd0;
      r_staged <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      if (r_fetch) begin
        r_lat <= r_lat + 3'd1;
        if (w_cap) begin
          r_stage  <= i_sram_data;
          r_staged <= 1'b1;
          r_fetch  <= 1'b0;
        end
      end else if (w_svc) begin
        r_staged <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_shift <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_mode  <= 1'b0;
      r_speed <= 4'd1;
      r_pause <= 1'b0;
    end else begin
      r_valid <= w_valid_n;
      r_shift <= w_shift_n;
      r_done  <= w_done_n;
      r_pause <= i_pause && (w_state_n != S_IDLE);
      if (w_svc) begin
        r_data  <= r_stage;
        r_mode  <= i_mode;
        r_speed <= w_s;
      end
    end
  end

`ifdef PLAY_CTRL_UNDERRUN_EN
  logic r_underrun;
  logic w_ur_set;
  logic w_ur_clr;

  // A tick landing on an already-pending tick is lost; remember that it happened.
  assign w_ur_set = (r_state == S_FETCH) && w_tick && r_pend && !i_stop;
  assign w_ur_clr = (r_state == S_IDLE) && i_start && !i_stop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_ur_clr) begin
      r_underrun <= 1'b0;
    end else if (w_ur_set) begin
      r_underrun <= 1'b1;
    end
  end

  assign o_underrun = r_underrun;
`else
  assign o_underrun = 1'b0;
`endif

  assign o_sram_addr = r_addr;
  assign o_sram_rd   = r_rd;
  assign o_valid     = r_valid;
  assign o_shift     = r_shift;
  assign o_done      = r_done;
  assign o_data      = r_data;
  assign o_itp_mode  = r_mode;
  assign o_itp_speed = r_speed;
  assign o_itp_pause = r_pause;
  assign o_busy      = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_play_ctrl.sv
// Bench for play_ctrl: SRAM model with fixed latency, randomized playback runs and a
// scoreboard comparing every valid/shift/done pulse against a sample-level model.
module tb_play_ctrl;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int RD_LAT = 4;
  localparam int EW     = 24;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_tick;
  logic              i_fast;
  logic [3:0]        i_speed;
  logic              i_mode;
  logic [ADDR_W-1:0] i_end_addr;
  logic [ADDR_W-1:0] o_sram_addr;
  logic              o_sram_rd;
  logic [DATA_W-1:0] i_sram_data;
  logic              o_valid;
  logic              o_shift;
  logic [DATA_W-1:0] o_data;
  logic              o_itp_mode;
  logic [3:0]        o_itp_speed;
  logic              o_itp_pause;
  logic              o_busy;
  logic              o_done;
  logic              o_underrun;
  logic [1:0]        o_dbg_state;

  play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_pause(i_pause),
    .i_stop(i_stop), .i_tick(i_tick), .i_fast(i_fast), .i_speed(i_speed),
    .i_mode(i_mode), .i_end_addr(i_end_addr), .o_sram_addr(o_sram_addr),
    .o_sram_rd(o_sram_rd), .i_sram_data(i_sram_data), .o_valid(o_valid),
    .o_shift(o_shift), .o_data(o_data), .o_itp_mode(o_itp_mode),
    .o_itp_speed(o_itp_speed), .o_itp_pause(o_itp_pause), .o_busy(o_busy),
    .o_done(o_done), .o_underrun(o_underrun), .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // SRAM: data appears exactly RD_LAT cycles after the strobe, zero otherwise
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge i_clk) begin
    pipe[0] <= o_sram_rd ? mem[o_sram_addr[5:0]] : '0;
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign i_sram_data = pipe[RD_LAT-1];

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] model_q[$];
  int checks = 0;
  int errors = 0;
  int events_seen = 0;
  logic [EW-1:0] mon_got;
  logic [EW-1:0] mon_exp;

  function automatic logic [EW-1:0] mk(input logic [2:0] kind, input logic [15:0] d,
                                       input logic [3:0] s, input logic m);
    return {kind, d, s, m};
  endfunction

  always @(negedge i_clk) begin
    if (i_rst_n && (o_valid || o_shift || o_done)) begin
      mon_got = {o_done, o_shift, o_valid, (o_valid ? o_data : 16'h0), o_itp_speed, o_itp_mode};
      events_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected output %h, nothing expected", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL event: got %h expected %h", mon_got, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: one event per tick, walking the sample list
  task automatic build(input int s_raw, input bit fast, input int end_a, input bit mode);
    int s;
    int a;
    int nxt;
    model_q.delete();
    s = (s_raw == 0) ? 1 : ((s_raw > 8) ? 8 : s_raw);
    a = 0;
    while (1) begin
      model_q.push_back(mk(3'b001, mem[a], 4'(s), mode));
      if (!fast) begin
        for (int j = 1; j < s; j++) model_q.push_back(mk(3'b010, 16'h0, 4'(s), mode));
      end
      nxt = a + (fast ? s : 1);
      if (nxt > end_a) begin
        model_q.push_back(mk(3'b100, 16'h0, 4'(s), mode));
        break;
      end
      a = nxt;
    end
  endtask

  // drivers (all inputs change 1 time unit after the active edge)
  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic start_play(input int s_raw, input bit fast, input int end_a, input bit mode,
                            input int npush, output int nev);
    i_speed    = 4'(s_raw);
    i_fast     = fast;
    i_end_addr = ADDR_W'(end_a);
    i_mode     = mode;
    build(s_raw, fast, end_a, mode);
    nev = model_q.size();
    for (int j = 0; j < nev; j++) begin
      if (npush < 0 || j < npush) exp_q.push_back(model_q[j]);
    end
    i_start = 1'b1;
    step(1);
    i_start = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) begin
      step($urandom_range(7, 12));
      i_tick = 1'b1;
      step(1);
      i_tick = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 60) begin
      step(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || o_busy) begin
      errors++;
      $display("FAIL %s drain: %0d events outstanding, busy=%0b, required 0 and 0",
               name, exp_q.size(), o_busy);
      exp_q.delete();
      i_stop = 1'b1;
      step(1);
      i_stop = 1'b0;
    end
    step(2);
  endtask

  initial begin
    int nev;
    int seen0;
    for (int k = 0; k < 64; k++) mem[k] = 16'($urandom);
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;
    i_rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0; i_tick = 1'b0;
    i_fast = 1'b0; i_speed = 4'd1; i_mode = 1'b0; i_end_addr = '0;
    step(3);

    chk("rst_addr", 32'(o_sram_addr), 0);
    chk("rst_rd", 32'(o_sram_rd), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_shift", 32'(o_shift), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_mode", 32'(o_itp_mode), 0);
    chk("rst_speed", 32'(o_itp_speed), 1);
    chk("rst_pause", 32'(o_itp_pause), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_underrun", 32'(o_underrun), 0);
    i_rst_n = 1'b1;
    step(2);

    // start -> read strobe one cycle later
    start_play(1, 0, 3, 1, -1, nev);
    chk("start_rd", 32'(o_sram_rd), 1);
    chk("start_busy", 32'(o_busy), 1);
    ticks(nev);
    wait_drain("normal");

    start_play(4, 0, 1, 0, -1, nev);
    ticks(nev);
    wait_drain("slow");

    start_play(3, 1, 7, 1, -1, nev);
    ticks(nev);
    wait_drain("fast");

    start_play(12, 1, 7, 0, -1, nev);
    ticks(nev);
    wait_drain("clamp");

    start_play(0, 0, 2, 1, -1, nev);
    ticks(nev);
    wait_drain("zero_speed");

    // pause after the second sample
    start_play(1, 0, 5, 0, -1, nev);
    ticks(2);
    step(3);
    i_pause = 1'b1;
    step(2);
    chk("pause_flag", 32'(o_itp_pause), 1);
    seen0 = events_seen;
    ticks(5);
    step(2);
    chk("pause_frozen", 32'(events_seen - seen0), 0);
    i_pause = 1'b0;
    ticks(nev - 2);
    wait_drain("pause");

    // stop in the middle of a held group
    start_play(4, 0, 3, 0, 2, nev);
    ticks(2);
    step(3);
    i_stop = 1'b1;
    step(1);
    i_stop = 1'b0;
    chk("stop_busy", 32'(o_busy), 0);
    chk("stop_addr", 32'(o_sram_addr), 0);
    seen0 = events_seen;
    ticks(3);
    step(3);
    chk("stop_silent", 32'(events_seen - seen0), 0);
    chk("stop_queue", 32'(exp_q.size()), 0);

    // two ticks during one fetch: only one sample comes out
    start_play(1, 0, 2, 1, -1, nev);
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
    step(1);
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
    ticks(nev - 1);
    wait_drain("underrun");
`ifdef PLAY_CTRL_UNDERRUN_EN
    chk("underrun_set", 32'(o_underrun), 1);
`else
    chk("underrun_set", 32'(o_underrun), 0);
`endif
    start_play(1, 0, 0, 0, -1, nev);
    chk("underrun_clr", 32'(o_underrun), 0);
    ticks(nev);
    wait_drain("after_underrun");

    // reset while a fetch is in flight
    start_play(2, 0, 4, 1, 0, nev);
    step(2);
    i_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(o_busy), 0);
    chk("rstmid_rd", 32'(o_sram_rd), 0);
    chk("rstmid_speed", 32'(o_itp_speed), 1);
    step(2);
    i_rst_n = 1'b1;
    step(2);

    for (int r = 0; r < 10; r++) begin
      start_play($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 20),
                 1'($urandom_range(0, 1)), -1, nev);
      ticks(nev);
      wait_drain("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
